bcd_share_arb: RTL and testbench
================================

Name: bcd_share_arb

Overview:
- Round-robin scheduler that shares one free-running 20-bit binary-to-ASCII BCD converter between NUM_REQ requesters (frequency, phase and amplitude display words of the DDS UI).
- The converter has no start or done handshake. This block drives its input word, waits a fixed window that covers a full reconversion, then captures the six ASCII digits.
- It returns the captured digits to the granted requester with a valid pulse and requester ID.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- CONV_WAIT, 90, cycles conv_data is held before capture. Must be ≥ 88, i.e. two full 44-cycle converter passes, so that at least one complete latch-and-convert pass occurs entirely with the new input.

Ports:
- sys_clk, in, 1, system clock 50 MHz.
- sys_rst, in, 1, reset. Synchronous, active-high.
- req, in, NUM_REQ, per-requester request level. Held until grant.
- req_data, in, NUM_REQ*20, packed binary words. Requester i uses bits [20i+19:20i]. Stable while req[i]=1.
- grant, out, NUM_REQ, one-hot, 1-cycle pulse on acceptance.
- busy, out, 1, high from grant until resp_valid inclusive.
- conv_data, out, 20, word driven to the converter.
- conv_unit / conv_ten / conv_hun / conv_tho / conv_t_tho / conv_h_hun, in, 8 each, ASCII digits from the converter.
- resp_valid, out, 1, 1-cycle pulse when resp_digits is valid.
- resp_id, out, 3, index of the requester being answered.
- resp_digits, out, 48, packed {h_hun,t_tho,tho,ten,hun,unit}, h_hun in MSBs.
- resp_ovf, out, 1, request value exceeded 999999 and was saturated.

Behaviour:
- Reset (sys_rst=1 at clock edge):
  - FSM goes to IDLE and the RR pointer goes to 0.
  - grant, busy, resp_valid, resp_id, resp_digits, resp_ovf and conv_data are all 0.
  - Reset mid-operation aborts with no response. The pending requester keeps req high and is re-arbitrated.
- States: IDLE, WAIT, CAPT, RESP.
- IDLE:
  - If any req bit is 1, pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Next cycle: grant[i]=1 for one cycle, busy=1, and conv_data is loaded. The pointer becomes (i+1) mod NUM_REQ, and the wait counter is cleared. Go to WAIT.
- Saturation: if req_data word > 999999, load conv_data = 999999 and set an internal ovf flag; otherwise load the word unchanged and clear the flag.
- WAIT:
  - Counter increments each cycle.
  - When counter == CONV_WAIT-1, go to CAPT.
  - Counter width is $clog2(CONV_WAIT+1).
- CAPT:
  - Register the six converter digits into resp_digits, after optional blanking.
  - Go to RESP.
- RESP:
  - resp_valid=1 for one cycle, with resp_id=i and resp_ovf=flag.
  - busy falls the following cycle. Go to IDLE.
- Latency: resp_valid is asserted exactly CONV_WAIT+2 cycles after the grant cycle.
- Hold rules:
  - conv_data holds its value between operations and changes only on a grant.
  - resp_digits, resp_id and resp_ovf hold until the next RESP.
- Request behaviour:
  - Requests arriving while busy are not lost; they are arbitrated in the first IDLE cycle after RESP.
  - A req dropped before its grant is simply not served.
  - A requester may re-request immediately after its grant.
- Simultaneous requests: strict round-robin. With all bits continuously set, grants go 0,1,2,0,…
- Back-to-back: IDLE occupies one cycle between RESP and the next grant. Minimum period is CONV_WAIT+4 cycles per conversion.

Optional Feature:
- Macro: BCD_LEAD_BLANK_EN.
- Defined: in CAPT, each leading "0" (0x30) digit from h_hun downward is replaced by ASCII space (0x20). Blanking stops at the first non-zero digit. unit is never blanked, so value 0 yields five spaces and "0".
- Undefined: digits are captured unmodified.
- Latency is identical in both builds.

Test Plan:
- Single request: req[0]=1, data=123456, behavioural converter model attached. Expect:
  - grant=001 one cycle later.
  - resp_valid exactly CONV_WAIT+2 cycles after grant.
  - resp_digits=48'h313233343536, resp_id=0, resp_ovf=0.
- Round-robin: req=111 held, data 11/22/33. Expect grants in order 001,010,100,001, and responses carry ids 0,1,2 with matching digits.
- Saturation: req[1]=1, data=20'hFFFFF (1048575). Expect conv_data=999999, resp_digits=48'h393939393939, resp_ovf=1.
- Blanking (macro defined):
  - data=42 → resp_digits=48'h202020203432.
  - data=0 → 48'h202020202030.
  - Same stimulus without the macro → 48'h303030303432.
- Reset mid-WAIT: assert sys_rst for 1 cycle 30 cycles after grant. Expect all outputs 0 and no resp_valid. With req still high, a fresh grant follows, and the response arrives CONV_WAIT+2 cycles after that new grant.
- Request during busy: req[2] rises 10 cycles into WAIT for req[0]. Expect grant[2] exactly 2 cycles after resp_valid of id 0 (the IDLE cycle, then grant).

Source files
------------

// File: rtl/bcd_share_arb.sv
// Round-robin arbiter sharing one free-running binary-to-ASCII BCD converter.
// Optional build macro BCD_LEAD_BLANK_EN blanks leading ASCII zeros to spaces.
module bcd_share_arb #(
  parameter int NUM_REQ   = 3,
  parameter int CONV_WAIT = 90
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*20-1:0]   req_data,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy,
  output logic [19:0]             conv_data,
  input  logic [7:0]              conv_unit,
  input  logic [7:0]              conv_ten,
  input  logic [7:0]              conv_hun,
  input  logic [7:0]              conv_tho,
  input  logic [7:0]              conv_t_tho,
  input  logic [7:0]              conv_h_hun,
  output logic                    resp_valid,
  output logic [2:0]              resp_id,
  output logic [47:0]             resp_digits,
  output logic                    resp_ovf,
  output logic [1:0]              state_dbg
);

  localparam int CNT_W = $clog2(CONV_WAIT + 1);
  localparam logic [19:0] MAX_DEC = 20'd999999;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT, S_RESP} state_t;

  state_t               state_q, state_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic [19:0]          conv_data_q, conv_data_d;
  logic                 ovf_q, ovf_d;
  logic [2:0]           cur_id_q, cur_id_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [2:0]           resp_id_q, resp_id_d;
  logic [47:0]          resp_digits_q, resp_digits_d;
  logic                 resp_ovf_q, resp_ovf_d;

  logic                 found;
  logic [2:0]           sel;
  logic [19:0]          sel_word;
  logic [47:0]          cap_digits;

  // First set request at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = 3'(idx);
      end
    end
  end

  assign sel_word = req_data[int'(sel)*20 +: 20];

  always_comb begin
    cap_digits = {conv_h_hun, conv_t_tho, conv_tho, conv_ten, conv_hun, conv_unit};
`ifdef BCD_LEAD_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      // unit (digit 0) is never blanked so a zero value still shows "0".
      for (int d = 5; d >= 1; d--) begin
        if (lead && cap_digits[d*8 +: 8] == 8'h30) cap_digits[d*8 +: 8] = 8'h20;
        else lead = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    grant_d       = '0;
    busy_d        = busy_q;
    conv_data_d   = conv_data_q;
    ovf_d         = ovf_q;
    cur_id_d      = cur_id_q;
    resp_valid_d  = 1'b0;
    resp_id_d     = resp_id_q;
    resp_digits_d = resp_digits_q;
    resp_ovf_d    = resp_ovf_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d[sel] = 1'b1;
          busy_d       = 1'b1;
          conv_data_d  = (sel_word > MAX_DEC) ? MAX_DEC : sel_word;
          ovf_d        = (sel_word > MAX_DEC);
          cur_id_d     = sel;
          ptr_d        = (sel == 3'(NUM_REQ - 1)) ? 3'd0 : sel + 3'd1;
          cnt_d        = '0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        // The grant cycle is the load cycle; counting starts after it.
        if (!grant_q) begin
          if (cnt_q == CNT_W'(CONV_WAIT - 1)) state_d = S_CAPT;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      S_CAPT: begin
        resp_digits_d = cap_digits;
        resp_id_d     = cur_id_q;
        resp_ovf_d    = ovf_q;
        resp_valid_d  = 1'b1;
        state_d       = S_RESP;
      end
      S_RESP: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      conv_data_q   <= '0;
      ovf_q         <= 1'b0;
      cur_id_q      <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_digits_q <= '0;
      resp_ovf_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      conv_data_q   <= conv_data_d;
      ovf_q         <= ovf_d;
      cur_id_q      <= cur_id_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_digits_q <= resp_digits_d;
      resp_ovf_q    <= resp_ovf_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign conv_data   = conv_data_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_digits = resp_digits_q;
  assign resp_ovf    = resp_ovf_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_bcd_share_arb.sv
// Bench for bcd_share_arb with a behavioural 44-cycle free-running BCD converter.
module tb_bcd_share_arb;
  localparam int NUM_REQ = 3;
  localparam int CW      = 90;
  localparam int LIMIT   = 400;

  logic                  clk = 1'b0;
  logic                  sys_rst;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*20-1:0] req_data;
  logic [NUM_REQ-1:0]    grant;
  logic                  busy;
  logic [19:0]           conv_data;
  logic [7:0]            c_unit, c_ten, c_hun, c_tho, c_t_tho, c_h_hun;
  logic                  resp_valid;
  logic [2:0]            resp_id;
  logic [47:0]           resp_digits;
  logic                  resp_ovf;
  logic [1:0]            state_dbg;

  int checks = 0;
  int failures = 0;
  logic [51:0] exp_q[$];

  bcd_share_arb #(.NUM_REQ(NUM_REQ), .CONV_WAIT(CW)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .req(req), .req_data(req_data),
    .grant(grant), .busy(busy), .conv_data(conv_data),
    .conv_unit(c_unit), .conv_ten(c_ten), .conv_hun(c_hun), .conv_tho(c_tho),
    .conv_t_tho(c_t_tho), .conv_h_hun(c_h_hun),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_digits(resp_digits),
    .resp_ovf(resp_ovf), .state_dbg(state_dbg)
  );

  always #10 clk = ~clk;

  function automatic logic [47:0] raw_ascii(input int v);
    logic [47:0] r;
    int x;
    x = v;
    for (int d = 0; d < 6; d++) begin
      r[d*8 +: 8] = 8'(8'h30 + x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Free-running converter: latches its input at pass start, publishes at pass end.
  logic [19:0] conv_lat;
  int phase = 17;
  always @(posedge clk) begin
    phase <= (phase == 43) ? 0 : phase + 1;
    if (phase == 0) conv_lat <= conv_data;
    if (phase == 43) {c_h_hun, c_t_tho, c_tho, c_ten, c_hun, c_unit} <= raw_ascii(int'(conv_lat));
  end
  initial {c_h_hun, c_t_tho, c_tho, c_ten, c_hun, c_unit} = 48'h303030303030;

  function automatic logic [47:0] model_digits(input logic [19:0] v);
    logic [47:0] r;
    r = raw_ascii((v > 20'd999999) ? 999999 : int'(v));
`ifdef BCD_LEAD_BLANK_EN
    for (int d = 5; d >= 1; d--) begin
      if (r[d*8 +: 8] == 8'h30) r[d*8 +: 8] = 8'h20;
      else break;
    end
`endif
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin tick(); n++; end while (grant == '0 && n < LIMIT);
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin tick(); n++; end while (!resp_valid && n < LIMIT);
  endtask

  task automatic check_resp(input string nm);
    logic [51:0] e;
    if (!resp_valid) begin
      chk({nm, "_resp_timeout"}, 64'(resp_valid), 64'd1);
    end else if (exp_q.size() == 0) begin
      chk({nm, "_unexpected_resp"}, 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_digits"}, 64'(resp_digits), 64'(e[47:0]));
      chk({nm, "_id"}, 64'(resp_id), 64'(e[50:48]));
      chk({nm, "_ovf"}, 64'(resp_ovf), 64'(e[51]));
    end
  endtask

  task automatic serve(input int id, input logic [19:0] data, input logic [47:0] dig, input logic ovf);
    int n;
    logic [NUM_REQ-1:0] eg;
    eg = '0;
    eg[id] = 1'b1;
    req_data[id*20 +: 20] = data;
    req[id] = 1'b1;
    wait_grant(n);
    chk("grant", 64'(grant), 64'(eg));
    chk("grant_delay", 64'(n), 64'd1);
    chk("busy_at_grant", 64'(busy), 64'd1);
    chk("conv_data", 64'(conv_data), (data > 20'd999999) ? 64'd999999 : 64'(data));
    req[id] = 1'b0;
    exp_q.push_back({ovf, 3'(id), dig});
    wait_resp(n);
    chk("latency", 64'(n), 64'(CW + 2));
    check_resp("serve");
    tick();
    chk("busy_after_resp", 64'(busy), 64'd0);
  endtask

  typedef struct {
    int          id;
    logic [19:0] data;
    logic [47:0] dig;
    logic        ovf;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int n;
    logic [NUM_REQ-1:0] eg;
    logic seen;

    vecs[0] = '{0, 20'd123456, 48'h313233343536, 1'b0};
    vecs[1] = '{1, 20'hFFFFF,  48'h393939393939, 1'b1};
`ifdef BCD_LEAD_BLANK_EN
    vecs[2] = '{2, 20'd42,     48'h202020203432, 1'b0};
    vecs[3] = '{0, 20'd0,      48'h202020202030, 1'b0};
`else
    vecs[2] = '{2, 20'd42,     48'h303030303432, 1'b0};
    vecs[3] = '{0, 20'd0,      48'h303030303030, 1'b0};
`endif
    vecs[4] = '{1, 20'd999999,  48'h393939393939, 1'b0};
    vecs[5] = '{2, 20'd1000000, 48'h393939393939, 1'b1};

    sys_rst = 1'b1;
    req = '0;
    req_data = '0;
    repeat (3) tick();
    sys_rst = 1'b0;
    chk("reset_outputs", 64'({grant, busy, resp_valid, resp_id, resp_ovf, conv_data}), 64'd0);
    chk("reset_digits", 64'(resp_digits), 64'd0);
    chk("reset_state", 64'(state_dbg), 64'd0);

    // Round-robin with all requests held.
    req_data = {20'd33, 20'd22, 20'd11};
    req = '1;
    for (int g = 0; g < 4; g++) begin
      wait_grant(n);
      eg = '0;
      eg[g % 3] = 1'b1;
      chk("rr_grant", 64'(grant), 64'(eg));
      exp_q.push_back({1'b0, 3'(g % 3), model_digits(req_data[(g % 3)*20 +: 20])});
      if (g == 3) req = '0;
      wait_resp(n);
      chk("rr_latency", 64'(n), 64'(CW + 2));
      check_resp("rr");
    end
    tick();

    foreach (vecs[i]) serve(vecs[i].id, vecs[i].data, vecs[i].dig, vecs[i].ovf);

    for (int r = 0; r < 3; r++) begin
      logic [19:0] v;
      int id;
      v = 20'($urandom_range(0, 20'hFFFFF));
      id = $urandom_range(0, NUM_REQ - 1);
      serve(id, v, model_digits(v), v > 20'd999999);
    end

    // Reset 30 cycles into WAIT aborts the response; the held request is re-served.
    req_data[19:0] = 20'd555;
    req[0] = 1'b1;
    wait_grant(n);
    chk("rst_first_grant", 64'(grant), 64'd1);
    exp_q.push_back({1'b0, 3'd0, model_digits(20'd555)});
    repeat (29) tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    exp_q.delete();
    chk("midrst_outputs", 64'({grant, busy, resp_valid, resp_id, resp_ovf, conv_data}), 64'd0);
    chk("midrst_digits", 64'(resp_digits), 64'd0);
    seen = 1'b0;
    n = 0;
    while (grant == '0 && n < LIMIT) begin
      tick();
      n++;
      if (resp_valid) seen = 1'b1;
    end
    chk("midrst_no_resp", 64'(seen), 64'd0);
    chk("midrst_regrant", 64'(grant), 64'd1);
    req[0] = 1'b0;
    exp_q.push_back({1'b0, 3'd0, model_digits(20'd555)});
    wait_resp(n);
    chk("midrst_latency", 64'(n), 64'(CW + 2));
    check_resp("midrst");
    tick();

    // Request arriving during busy is served right after the IDLE cycle.
    req_data[19:0] = 20'd7;
    req_data[59:40] = 20'd8;
    req[0] = 1'b1;
    wait_grant(n);
    chk("busyreq_grant0", 64'(grant), 64'd1);
    req[0] = 1'b0;
    exp_q.push_back({1'b0, 3'd0, model_digits(20'd7)});
    repeat (10) tick();
    req[2] = 1'b1;
    wait_resp(n);
    check_resp("busyreq0");
    wait_grant(n);
    chk("busyreq_grant2", 64'(grant), 64'b100);
    chk("busyreq_gap", 64'(n), 64'd2);
    req[2] = 1'b0;
    exp_q.push_back({1'b0, 3'd2, model_digits(20'd8)});
    wait_resp(n);
    chk("busyreq_latency", 64'(n), 64'(CW + 2));
    check_resp("busyreq2");
    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
